// File: rtl/finish_delay_line_if.sv
// Strobe/join bundle between the layer engines, the delay line and the
// top-level sequencer. Delay and mask fields are quasi-static configuration.
interface finish_delay_line_if #(
    parameter int NCH   = 4,
    parameter int DLY_W = 5
);
    logic [NCH-1:0]       din;
    logic [NCH*DLY_W-1:0] dly;
    logic [NCH-1:0]       mask;
    logic [NCH-1:0]       dout;
    logic                 all_done;
    logic [NCH-1:0]       ovf;

    modport master (
        output din, dly, mask,
        input  dout, all_done, ovf
    );

    modport slave (
        input  din, dly, mask,
        output dout, all_done, ovf
    );
endinterface

// File: rtl/finish_delay_line.sv
// Multi-channel programmable delay line for layer finish strobes, followed
// by a sticky join that pulses all_done once every masked channel has
// delivered its delayed strobe.

// One channel: a plain shift register with a clamped, selectable tap.
module finish_delay_lane #(
    parameter int MAX_DLY = 16,
    parameter int DLY_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             din,
    input  logic [DLY_W-1:0] dly,
    output logic             dout
);
    logic [MAX_DLY-1:0] sr;
    logic [DLY_W-1:0]   d_eff;

    // Shift every cycle; every strobe keeps its own slot, so back-to-back
    // strobes never merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int k = 1; k < MAX_DLY; k++) sr[k] <= sr[k-1];
        end
    end

    // Saturate the programmed delay into 1..MAX_DLY.
    always_comb begin
        d_eff = dly;
        if (dly == '0)
            d_eff = DLY_W'(1);
        else if (dly > DLY_W'(MAX_DLY))
            d_eff = DLY_W'(MAX_DLY);
    end

    // Tap mux: dout comes straight from a register bit, never from din.
    always_comb begin
        dout = 1'b0;
        for (int k = 0; k < MAX_DLY; k++)
            if (d_eff == DLY_W'(k + 1)) dout = sr[k];
    end
endmodule

module finish_delay_line #(
    parameter int NCH     = 4,
    parameter int MAX_DLY = 16,
    parameter int DLY_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    finish_delay_line_if.slave bus
);
    logic [NCH-1:0] dout_w;
    logic [NCH-1:0] flag;
    logic [NCH-1:0] arr;
    logic [NCH-1:0] pend;
    logic           complete;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
        finish_delay_lane #(
            .MAX_DLY (MAX_DLY),
            .DLY_W   (DLY_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .din   (bus.din[gi]),
            .dly   (bus.dly[gi*DLY_W +: DLY_W]),
            .dout  (dout_w[gi])
        );
    end

    assign bus.dout = dout_w;

    // Join: a round completes once flagged plus arriving channels cover the mask.
    always_comb begin
        arr      = dout_w & bus.mask;
        pend     = flag | arr;
        complete = (bus.mask != '0) && ((pend & bus.mask) == bus.mask);
    end

    // Join state: an arrival coinciding with completion is consumed by that
    // round, so it neither overruns nor carries into the next one. Flags are
    // kept masked so a stale bit cannot linger after a mask change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag         <= '0;
            bus.all_done <= 1'b0;
            bus.ovf      <= '0;
        end else if (clr) begin
            flag         <= '0;
            bus.all_done <= 1'b0;
            bus.ovf      <= '0;
        end else begin
            bus.all_done <= complete;
            flag         <= complete ? '0 : (pend & bus.mask);
            bus.ovf      <= bus.ovf | (arr & flag & {NCH{~complete}});
        end
    end
endmodule

// File: tb/tb_finish_delay_line.sv
// Bench for finish_delay_line: constant-table latency vectors, hand-written
// corner sequences, then random traffic against an event-queue model.
module tb_finish_delay_line;
    localparam int NCH     = 4;
    localparam int MAX_DLY = 16;
    localparam int DLY_W   = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;

    finish_delay_line_if #(.NCH(NCH), .DLY_W(DLY_W)) bus ();

    finish_delay_line #(.NCH(NCH), .MAX_DLY(MAX_DLY), .DLY_W(DLY_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: each strobe is scheduled as a due edge number; the join tracks
    // the set of channels that have already arrived in the current round.
    int             e = 0;
    int             due [NCH][$];
    logic [NCH-1:0] m_dout, m_arr, m_ovf;
    logic           m_done;

    typedef struct {
        logic [DLY_W-1:0] d;
        int               lat;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int eff(input logic [DLY_W-1:0] d);
        if (int'(d) == 0) return 1;
        if (int'(d) > MAX_DLY) return MAX_DLY;
        return int'(d);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) due[i].delete();
        m_dout = '0;
        m_arr  = '0;
        m_ovf  = '0;
        m_done = 1'b0;
    endtask

    // Advance the model over the coming edge, then take the edge.
    task automatic tick();
        logic [NCH-1:0] a;
        logic           c;
        e++;
        if (clr) begin
            model_clear();
        end else begin
            a = m_dout & bus.mask;
            c = (bus.mask != '0) && (((m_arr | a) & bus.mask) == bus.mask);
            m_done = c;
            if (c) m_arr = '0;
            else begin
                m_ovf = m_ovf | (a & m_arr);
                m_arr = m_arr | a;
            end
            for (int i = 0; i < NCH; i++)
                if (bus.din[i]) due[i].push_back(e + eff(bus.dly[i*DLY_W +: DLY_W]) - 1);
            for (int i = 0; i < NCH; i++) begin
                m_dout[i] = 1'b0;
                if (due[i].size() > 0 && due[i][0] == e) begin
                    m_dout[i] = 1'b1;
                    void'(due[i].pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_dout"}, 32'(bus.dout), 32'h0);
        chk({nm, "_done"}, 32'(bus.all_done), 32'h0);
        chk({nm, "_ovf"}, 32'(bus.ovf), 32'h0);
    endtask

    task automatic chk_model(input string nm);
        chk({nm, "_dout"}, 32'(bus.dout), 32'(m_dout));
        chk({nm, "_done"}, 32'(bus.all_done), 32'(m_done));
        chk({nm, "_ovf"}, 32'(bus.ovf), 32'(m_ovf));
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        bus.dly = {DLY_W'(d3), DLY_W'(d2), DLY_W'(d1), DLY_W'(d0)};
    endtask

    task automatic do_clr();
        clr = 1'b1;
        bus.din = '0;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int lat4 [4];
        logic [NCH-1:0] ed;

        vecs[0] = '{d: 5'd1,  lat: 1};
        vecs[1] = '{d: 5'd3,  lat: 3};
        vecs[2] = '{d: 5'd7,  lat: 7};
        vecs[3] = '{d: 5'd16, lat: 16};
        vecs[4] = '{d: 5'd0,  lat: 1};
        vecs[5] = '{d: 5'd31, lat: 16};
        vecs[6] = '{d: 5'd2,  lat: 2};
        vecs[7] = '{d: 5'd17, lat: 16};

        // Reset with din high: everything must read 0.
        rst_n = 1'b0;
        clr = 1'b0;
        bus.din = 4'hF;
        bus.mask = 4'hF;
        set_dly(1, 1, 1, 1);
        model_clear();
        #1;
        chk_zero("rst_t0");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_zero("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.din = '0;
        e = 0;
        model_clear();
        for (int k = 0; k < 40; k++) begin
            tick();
            chk_zero("idle");
        end

        // Uniform delay table, including saturation of 0 and >MAX_DLY.
        foreach (vecs[v]) begin
            bus.dly = {NCH{vecs[v].d}};
            bus.mask = 4'hF;
            do_clr();
            bus.din = 4'hF;
            tick();
            bus.din = '0;
            for (int k = 1; k <= vecs[v].lat + 2; k++) begin
                chk("tbl_dout", 32'(bus.dout), (k == vecs[v].lat) ? 32'hF : 32'h0);
                chk("tbl_done", 32'(bus.all_done), (k == vecs[v].lat + 1) ? 32'h1 : 32'h0);
                tick();
            end
        end

        // Per-channel sweep {1,3,7,16}.
        lat4 = '{1, 3, 7, 16};
        set_dly(1, 3, 7, 16);
        bus.mask = 4'hF;
        do_clr();
        bus.din = 4'hF;
        tick();
        bus.din = '0;
        for (int k = 1; k <= 18; k++) begin
            for (int i = 0; i < NCH; i++) ed[i] = (k == lat4[i]);
            chk("sweep_dout", 32'(bus.dout), 32'(ed));
            chk("sweep_done", 32'(bus.all_done), (k == 17) ? 32'h1 : 32'h0);
            tick();
        end

        // Back-to-back burst of 5 on channel 0 with delay 4.
        set_dly(4, 4, 4, 4);
        bus.mask = 4'h1;
        do_clr();
        for (int k = 1; k <= 11; k++) begin
            bus.din = (k <= 5) ? 4'h1 : 4'h0;
            tick();
            chk("b2b_dout", 32'(bus.dout), (k >= 4 && k <= 8) ? 32'h1 : 32'h0);
            chk("b2b_done", 32'(bus.all_done), (k >= 5 && k <= 9) ? 32'h1 : 32'h0);
            chk("b2b_ovf", 32'(bus.ovf), 32'h0);
        end

        // Join with overrun on ch0; ch2 traffic is outside the mask.
        set_dly(2, 2, 2, 2);
        bus.mask = 4'b0011;
        do_clr();
        for (int k = 1; k <= 16; k++) begin
            bus.din = (k == 5 || k == 8) ? 4'h1 : (k == 12) ? 4'h2 : (k == 3 || k == 9) ? 4'h4 : 4'h0;
            tick();
            chk("join_ovf", 32'(bus.ovf), (k >= 10) ? 32'h1 : 32'h0);
            chk("join_done", 32'(bus.all_done), (k == 14) ? 32'h1 : 32'h0);
        end

        // Coincident completion: flagged ch0 re-arrives together with ch1.
        do_clr();
        for (int k = 1; k <= 15; k++) begin
            bus.din = (k == 1 || k == 12) ? 4'h1 : (k == 4) ? 4'h3 : (k == 8) ? 4'h2 : 4'h0;
            tick();
            chk("coin_done", 32'(bus.all_done), (k == 6 || k == 14) ? 32'h1 : 32'h0);
            chk("coin_ovf", 32'(bus.ovf), 32'h0);
        end

        // Clear with strobes in flight and ovf set.
        set_dly(8, 8, 8, 8);
        bus.mask = 4'b0011;
        do_clr();
        for (int k = 1; k <= 12; k++) begin
            bus.din = (k == 1 || k == 2) ? 4'h1 : (k >= 10) ? 4'hF : 4'h0;
            tick();
            if (k >= 10) chk("clr_pre_ovf", 32'(bus.ovf), 32'h1);
        end
        do_clr();
        for (int k = 0; k < 20; k++) begin
            chk_zero("clr_post");
            tick();
        end

        // Asynchronous reset between edges while dout is high.
        bus.mask = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            bus.din = (k <= 3) ? 4'hF : 4'h0;
            tick();
        end
        chk("arst_pre_dout", 32'(bus.dout), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("arst_now");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int k = 0; k < 20; k++) begin
            tick();
            chk_zero("arst_post");
        end

        // Random traffic against the model; config changes go through clr.
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < NCH; i++) bus.dly[i*DLY_W +: DLY_W] = DLY_W'($urandom_range(0, 31));
            bus.mask = NCH'($urandom_range(0, 15));
            do_clr();
            chk_model("rnd_clr");
            for (int k = 0; k < 300; k++) begin
                for (int i = 0; i < NCH; i++) bus.din[i] = ($urandom_range(0, 9) < 3);
                clr = ($urandom_range(0, 63) == 0);
                tick();
                chk_model("rnd");
            end
            clr = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
